ltc_gen: RTL and testbench

Parametrised SMPTE linear timecode (LTC) generator. It is the successor to the fixed 12 MHz LTC block. The internal HH:MM:SS:FF counter runs at 24, 25, 30 drop-frame or 30 non-drop fps, and the block emits the 80-bit biphase-mark LTC stream. It adds clock-frequency parameterisation, a BCD preset load, 32 user bits, run/stop control at frame boundaries and status outputs. It sits between the chip's top-level I/O pins and the audio-rate LTC output pad.

---
 rtl/ltc_gen.sv | 220 ++++++++++++++++++++++
 tb/tb_ltc_gen.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ltc_gen.sv
// SMPTE linear timecode generator: HH:MM:SS:FF counter at 24/25/30DF/30 fps
// driving an 80-bit biphase-mark LTC stream with preset load and user bits.
module ltc_gen #(
    parameter int CLK_HZ = 12_000_000,
    parameter int DIV_W  = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  framerate,
    input  logic        run,
    input  logic        load,
    input  logic [25:0] preset,
    input  logic [31:0] user_bits,
    output logic        ltc,
    output logic        frame_start,
    output logic [25:0] tc_bcd,
    output logic        busy,
    output logic        state_dbg
);

    localparam int HALF_24 = CLK_HZ / 3840;
    localparam int HALF_25 = CLK_HZ / 4000;
    localparam int HALF_30 = CLK_HZ / 4800;

    localparam logic [DIV_W-1:0] HM_24 = DIV_W'(HALF_24 - 1);
    localparam logic [DIV_W-1:0] HM_25 = DIV_W'(HALF_25 - 1);
    localparam logic [DIV_W-1:0] HM_30 = DIV_W'(HALF_30 - 1);

    if ((CLK_HZ % 3840) != 0 || (CLK_HZ % 4000) != 0 || (CLK_HZ % 4800) != 0) begin : g_bad_clk
        $error("ltc_gen: CLK_HZ must be divisible by 3840, 4000 and 4800");
    end

    if (longint'(HALF_24 - 1) >= (longint'(1) << DIV_W)) begin : g_bad_div
        $error("ltc_gen: DIV_W too narrow for CLK_HZ/3840 - 1");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            state;
    logic [DIV_W-1:0]  div;
    logic [6:0]        bit_idx;
    logic              second_half;
    logic [79:0]       word;
    logic [1:0]        fr_q;
    logic [25:0]       cnt;

    logic [DIV_W-1:0]  half_max;
    logic              half_done;
    logic              frame_end;
    logic              capture;
    logic [25:0]       next_tc;
    logic [79:0]       word_base;
    logic              par;
    logic [79:0]       new_word;

    // Advance the BCD time by one frame; >= compares let bad preset digits wrap.
    function automatic logic [25:0] tc_advance(input logic [25:0] t, input logic [1:0] fr);
        logic [1:0] hd;
        logic [3:0] hu;
        logic [2:0] md;
        logic [3:0] mu;
        logic [2:0] sd;
        logic [3:0] su;
        logic [1:0] fd;
        logic [3:0] fu;
        logic [3:0] fmax_u;
        logic       c_s;
        logic       c_m;
        logic       c_h;
        {hd, hu, md, mu, sd, su, fd, fu} = t;
        fmax_u = (fr == 2'b00) ? 4'd3 : (fr == 2'b01) ? 4'd4 : 4'd9;
        c_s = 1'b0;
        c_m = 1'b0;
        c_h = 1'b0;
        if (fd > 2'd2 || (fd == 2'd2 && fu >= fmax_u)) begin
            fd  = 2'd0;
            fu  = 4'd0;
            c_s = 1'b1;
        end else if (fu >= 4'd9) begin
            fu = 4'd0;
            fd = fd + 2'd1;
        end else begin
            fu = fu + 4'd1;
        end
        if (c_s) begin
            if (su >= 4'd9) begin
                su = 4'd0;
                if (sd >= 3'd5) begin
                    sd  = 3'd0;
                    c_m = 1'b1;
                end else begin
                    sd = sd + 3'd1;
                end
            end else begin
                su = su + 4'd1;
            end
        end
        if (c_m) begin
            if (mu >= 4'd9) begin
                mu = 4'd0;
                if (md >= 3'd5) begin
                    md  = 3'd0;
                    c_h = 1'b1;
                end else begin
                    md = md + 3'd1;
                end
            end else begin
                mu = mu + 4'd1;
            end
        end
        if (c_h) begin
            if (hd >= 2'd2 && hu >= 4'd3) begin
                hd = 2'd0;
                hu = 4'd0;
            end else if (hu >= 4'd9) begin
                hu = 4'd0;
                hd = hd + 2'd1;
            end else begin
                hu = hu + 4'd1;
            end
        end
        // Drop-frame numbering skips ff 00/01 at the start of minutes not divisible by ten.
        if (fr == 2'b10 && c_m && mu != 4'd0) begin
            fu = 4'd2;
        end
        return {hd, hu, md, mu, sd, su, fd, fu};
    endfunction

    always_comb begin
        half_max = HM_30;
        case (fr_q)
            2'b00:   half_max = HM_24;
            2'b01:   half_max = HM_25;
            default: half_max = HM_30;
        endcase
    end

    assign half_done = (div == half_max);
    assign frame_end = (state == S_RUN) && half_done && second_half && (bit_idx == 7'd79);
    assign capture   = ((state == S_IDLE) && run) || (frame_end && run);
    assign next_tc   = tc_advance(cnt, framerate);

    // Bit 0 ends up at the LSB; both polarity slots start cleared.
    assign word_base = {16'hBFFC,
                        user_bits[31:28], 1'b0, 1'b0, cnt[25:24],
                        user_bits[27:24], cnt[23:20],
                        user_bits[23:20], 1'b0, cnt[19:17],
                        user_bits[19:16], cnt[16:13],
                        user_bits[15:12], 1'b0, cnt[12:10],
                        user_bits[11:8],  cnt[9:6],
                        user_bits[7:4],   1'b0, (framerate == 2'b10), cnt[5:4],
                        user_bits[3:0],   cnt[3:0]};
    assign par      = ^word_base;
    assign new_word = word_base
                    | (80'(par & (framerate == 2'b01)) << 59)
                    | (80'(par & (framerate != 2'b01)) << 27);

    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            div         <= '0;
            bit_idx     <= 7'd0;
            second_half <= 1'b0;
            word        <= '0;
            fr_q        <= 2'b00;
            cnt         <= '0;
            ltc         <= 1'b0;
            frame_start <= 1'b0;
            tc_bcd      <= '0;
            busy        <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (capture) begin
                state       <= S_RUN;
                busy        <= 1'b1;
                fr_q        <= framerate;
                word        <= new_word;
                tc_bcd      <= cnt;
                frame_start <= 1'b1;
                ltc         <= ~ltc;
                div         <= '0;
                bit_idx     <= 7'd0;
                second_half <= 1'b0;
            end else if (state == S_RUN) begin
                if (frame_end) begin
                    state       <= S_IDLE;
                    busy        <= 1'b0;
                    div         <= '0;
                    bit_idx     <= 7'd0;
                    second_half <= 1'b0;
                end else if (half_done) begin
                    div <= '0;
                    if (!second_half) begin
                        second_half <= 1'b1;
                        if (word[bit_idx]) begin
                            ltc <= ~ltc;
                        end
                    end else begin
                        second_half <= 1'b0;
                        bit_idx     <= bit_idx + 7'd1;
                        ltc         <= ~ltc;
                    end
                end else begin
                    div <= div + 1'b1;
                end
            end
            if (load) begin
                cnt <= preset;
            end else if (capture) begin
                cnt <= next_tc;
            end
        end
    end

endmodule

// File: tb/tb_ltc_gen.sv
// Bench for ltc_gen at a reduced clock (96 kHz) so frames are 3200-4000 cycles;
// a monitor decodes each LTC frame and compares it with queued expectations.
module tb_ltc_gen;

    localparam int CLK_HZ = 96000;
    localparam int DIV_W  = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  framerate;
    logic        run;
    logic        load;
    logic [25:0] preset;
    logic [31:0] user_bits;
    logic        ltc;
    logic        frame_start;
    logic [25:0] tc_bcd;
    logic        busy;
    logic        state_dbg;

    ltc_gen #(.CLK_HZ(CLK_HZ), .DIV_W(DIV_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .framerate   (framerate),
        .run         (run),
        .load        (load),
        .preset      (preset),
        .user_bits   (user_bits),
        .ltc         (ltc),
        .frame_start (frame_start),
        .tc_bcd      (tc_bcd),
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] gap;
        logic [15:0] half;
        logic [25:0] tc;
        logic [79:0] word;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b1;
    bit   mon_busy = 1'b0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [25:0] tc(input int hh, input int mm, input int ss, input int ff);
        logic [1:0] hd;
        logic [3:0] hu;
        logic [2:0] md;
        logic [3:0] mu;
        logic [2:0] sd;
        logic [3:0] su;
        logic [1:0] fd;
        logic [3:0] fu;
        hd = 2'(hh / 10); hu = 4'(hh % 10);
        md = 3'(mm / 10); mu = 4'(mm % 10);
        sd = 3'(ss / 10); su = 4'(ss % 10);
        fd = 2'(ff / 10); fu = 4'(ff % 10);
        return {hd, hu, md, mu, sd, su, fd, fu};
    endfunction

    function automatic int half_of(input logic [1:0] fr);
        return (fr == 2'b00) ? 25 : (fr == 2'b01) ? 24 : 20;
    endfunction

    function automatic logic [79:0] mk_word(input logic [25:0] t, input logic [31:0] ub, input logic [1:0] fr);
        logic [79:0] w;
        logic [15:0] sync;
        logic        p;
        sync      = 16'hBFFC;
        w         = '0;
        w[3:0]    = t[3:0];
        w[7:4]    = ub[3:0];
        w[9:8]    = t[5:4];
        w[10]     = (fr == 2'b10);
        w[15:12]  = ub[7:4];
        w[19:16]  = t[9:6];
        w[23:20]  = ub[11:8];
        w[26:24]  = t[12:10];
        w[31:28]  = ub[15:12];
        w[35:32]  = t[16:13];
        w[39:36]  = ub[19:16];
        w[42:40]  = t[19:17];
        w[47:44]  = ub[23:20];
        w[51:48]  = t[23:20];
        w[55:52]  = ub[27:24];
        w[57:56]  = t[25:24];
        w[63:60]  = ub[31:28];
        w[79:64]  = sync;
        p = ^w;
        if (fr == 2'b01) w[59] = p;
        else             w[27] = p;
        return w;
    endfunction

    task automatic push(input logic [25:0] t, input logic [31:0] ub, input logic [1:0] fr, input int gap);
        exp_t e;
        e.gap  = 32'(gap);
        e.half = 16'(half_of(fr));
        e.tc   = t;
        e.word = mk_word(t, ub, fr);
        exp_q.push_back(e);
    endtask

    task automatic wait_fs(input string name, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 10000);
        if (!frame_start) begin
            checks++;
            failures++;
            $display("FAIL %s: no frame_start within %0d cycles", name, n);
        end
    endtask

    task automatic wait_idle(input string name, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 10000);
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL %s: busy still high after %0d cycles", name, n);
        end
    endtask

    task automatic load_preset(input logic [25:0] p);
        preset = p;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    task automatic run_seq(input string name, input int nframes);
        int n;
        run = 1'b1;
        for (int i = 0; i < nframes; i++) begin
            wait_fs(name, n);
            if (i == nframes - 1) run = 1'b0;
        end
        wait_idle(name, n);
    endtask

    // Monitor: decode each frame by sampling the middle of both bit halves.
    initial begin : monitor
        exp_t        e;
        logic        prev_ltc;
        logic        first_h;
        logic        last_second;
        logic [79:0] dec;
        int          toggle_err;
        int          fs_err;
        int          last_fs;
        prev_ltc    = 1'b0;
        last_fs     = 0;
        first_h     = 1'b0;
        last_second = 1'b0;
        @(negedge clk);
        forever begin
            if (frame_start && mon_en) begin
                mon_busy = 1'b1;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame: tc_bcd %0h with empty queue", tc_bcd);
                end else begin
                    e = exp_q.pop_front();
                    check("tc_bcd", 128'(tc_bcd), 128'(e.tc));
                    if (e.gap != 0) check("frame_gap", 128'(cyc - last_fs), 128'(e.gap));
                    last_fs    = cyc;
                    toggle_err = (ltc == prev_ltc) ? 1 : 0;
                    fs_err     = 0;
                    dec        = '0;
                    for (int c = 0; c < 160 * int'(e.half); c++) begin
                        int h;
                        int b;
                        int off;
                        if (c > 0) begin
                            @(negedge clk);
                            if (frame_start) fs_err++;
                        end
                        h   = int'(e.half);
                        b   = c / (2 * h);
                        off = c % (2 * h);
                        if (off == h / 2) begin
                            first_h = ltc;
                            if (b > 0 && first_h == last_second) toggle_err++;
                        end
                        if (off == h + h / 2) begin
                            last_second = ltc;
                            dec[b]      = first_h ^ ltc;
                        end
                    end
                    check("ltc_word", 128'(dec), 128'(e.word));
                    check("word_parity", 128'(^dec), 128'(0));
                    check("bit_edges", 128'(toggle_err), 128'(0));
                    check("fs_pulse", 128'(fs_err), 128'(0));
                end
                mon_busy = 1'b0;
            end
            prev_ltc = ltc;
            @(negedge clk);
        end
    end

    initial begin : stimulus
        int          n;
        int          errs;
        logic        lvl;
        logic [31:0] ub;
        logic [25:0] raw;

        reset_n   = 1'b0;
        run       = 1'b0;
        load      = 1'b0;
        framerate = 2'b01;
        preset    = '0;
        ub        = 32'h1234_ABCD;
        user_bits = ub;
        repeat (3) @(negedge clk);
        check("rst_ltc", 128'(ltc), 128'(0));
        check("rst_frame_start", 128'(frame_start), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_tc_bcd", 128'(tc_bcd), 128'(0));
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_busy", 128'(busy), 128'(0));
        check("idle_state", 128'(state_dbg), 128'(0));

        // 25 fps from reset, stop mid-stream, then restart
        push(tc(0, 0, 0, 0), ub, 2'b01, 0);
        push(tc(0, 0, 0, 1), ub, 2'b01, 3840);
        run = 1'b1;
        wait_fs("t1_f0", n);
        check("start_latency", 128'(n), 128'(1));
        wait_fs("t1_f1", n);
        run = 1'b0;
        wait_idle("t1_stop", n);
        check("stop_cycles", 128'(n), 128'(3840));
        lvl  = ltc;
        errs = 0;
        repeat (40) begin
            @(negedge clk);
            if (ltc !== lvl || frame_start || busy) errs++;
        end
        check("idle_hold", 128'(errs), 128'(0));
        push(tc(0, 0, 0, 2), ub, 2'b01, 0);
        run = 1'b1;
        wait_fs("t1_restart", n);
        check("restart_latency", 128'(n), 128'(1));
        run = 1'b0;
        wait_idle("t1_restart_stop", n);

        // 25 fps rollover from 23:59:59:24
        ub        = 32'hFEDC_0123;
        user_bits = ub;
        load_preset(tc(23, 59, 59, 24));
        push(tc(23, 59, 59, 24), ub, 2'b01, 0);
        push(tc(0, 0, 0, 0), ub, 2'b01, 3840);
        run_seq("t2", 2);

        // 30 drop-frame, with a preset loaded mid-frame
        framerate = 2'b10;
        ub        = 32'h5A5A_C3C3;
        user_bits = ub;
        load_preset(tc(0, 0, 59, 29));
        push(tc(0, 0, 59, 29), ub, 2'b10, 0);
        push(tc(0, 1, 0, 2), ub, 2'b10, 3200);
        push(tc(0, 9, 59, 29), ub, 2'b10, 3200);
        push(tc(0, 10, 0, 0), ub, 2'b10, 3200);
        run = 1'b1;
        wait_fs("t3_a", n);
        wait_fs("t3_b", n);
        repeat (100) @(negedge clk);
        load_preset(tc(0, 9, 59, 29));
        wait_fs("t3_c", n);
        wait_fs("t3_d", n);
        run = 1'b0;
        wait_idle("t3_stop", n);

        // 24 fps rollover, then framerate switched to 30 mid-frame
        framerate = 2'b00;
        ub        = 32'h0F1E_2D3C;
        user_bits = ub;
        load_preset(tc(19, 59, 59, 23));
        push(tc(19, 59, 59, 23), ub, 2'b00, 0);
        push(tc(20, 0, 0, 0), ub, 2'b11, 4000);
        run = 1'b1;
        wait_fs("t4_a", n);
        repeat (10) @(negedge clk);
        framerate = 2'b11;
        wait_fs("t4_b", n);
        run = 1'b0;
        wait_idle("t4_stop", n);

        // 30 non-drop: out-of-range seconds digit, then minute boundary without drop
        ub        = 32'h8765_4321;
        user_bits = ub;
        raw       = {2'd0, 4'd0, 3'd0, 4'd0, 3'd0, 4'hC, 2'd2, 4'd9};
        load_preset(raw);
        push(raw, ub, 2'b11, 0);
        push(tc(0, 0, 10, 0), ub, 2'b11, 3200);
        push(tc(0, 0, 59, 29), ub, 2'b11, 3200);
        push(tc(0, 1, 0, 0), ub, 2'b11, 3200);
        run = 1'b1;
        wait_fs("t5_a", n);
        wait_fs("t5_b", n);
        repeat (50) @(negedge clk);
        load_preset(tc(0, 0, 59, 29));
        wait_fs("t5_c", n);
        wait_fs("t5_d", n);
        run = 1'b0;
        wait_idle("t5_stop", n);

        // Asynchronous reset in the middle of a frame
        mon_en    = 1'b0;
        framerate = 2'b01;
        run       = 1'b1;
        wait_fs("t6_a", n);
        check("pre_reset_tc", 128'(tc_bcd), 128'(tc(0, 1, 0, 1)));
        n = 0;
        while (ltc !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("pre_reset_ltc", 128'(ltc), 128'(1));
        #2 reset_n = 1'b0;
        #1;
        check("async_ltc", 128'(ltc), 128'(0));
        check("async_frame_start", 128'(frame_start), 128'(0));
        check("async_busy", 128'(busy), 128'(0));
        check("async_tc_bcd", 128'(tc_bcd), 128'(0));
        run = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        push(tc(0, 0, 0, 0), ub, 2'b01, 0);
        run_seq("t6_after", 1);

        n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < 10000) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #1_500_000;
        checks++;
        failures++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
